ysyx_24100005_ifu: RTL and testbench

//  Instruction fetch unit, directly upstream of the single-cycle core datapath. Owns the PC.

---
 rtl/ysyx_24100005_pkg.sv | 17 +
 rtl/ysyx_24100005_ifu_wdog.sv | 23 ++
 rtl/ysyx_24100005_ifu.sv | 139 +++++++++++++
 tb/tb_ysyx_24100005_ifu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_pkg.sv
// Shared types and constants for the ysyx_24100005 instruction fetch unit.
package ysyx_24100005_pkg;

    localparam int          WORD_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_ZERO    = 32'h0000_0000;
    localparam int          TIMEOUT_DEF  = 255;

    // Fetch FSM: issue request, wait for data, hold for decode, wait for next PC
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        EXEC = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ysyx_24100005_ifu_wdog.sv
// WAIT-state watchdog: 8-bit up-counter, cleared outside WAIT, flags expiry at LIMIT.
module ysyx_24100005_ifu_wdog #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic i_clk,
    input  logic i_rst,      // active-low, asynchronous
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_cnt;

    assign o_expired = (r_cnt == LIMIT);

    // Count WAIT cycles; saturate once expired so the flag stays up until cleared
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                  r_cnt <= 8'd0;
        else if (i_clr)              r_cnt <= 8'd0;
        else if (i_en && !o_expired) r_cnt <= r_cnt + 8'd1;
    end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// valid/ready bus and hands {pc, inst} to the single-cycle core.
// Optional feature macro: YSYX_IFU_FAULT_EN (misaligned-PC, bus-error and
// WAIT-timeout faults reported on o_inst_fault). Without it o_inst_fault is 0.
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int                TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,        // active-low, asynchronous
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [WORD_W-1:0] o_req_addr,
    input  logic              i_resp_valid,
    output logic              o_resp_ready,
    input  logic [WORD_W-1:0] i_resp_data,
    input  logic              i_resp_err,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [WORD_W-1:0] o_inst,
    output logic [WORD_W-1:0] o_pc,
    input  logic              i_wb_valid,
    input  logic [WORD_W-1:0] i_wb_npc,
    output logic              o_inst_fault
);

    localparam logic [7:0] TO_LIM = TIMEOUT_CYC[7:0];

    ifu_state_t        r_state, w_state_nxt;
    logic [WORD_W-1:0] r_pc, w_pc_nxt;
    logic [WORD_W-1:0] r_inst, w_inst_nxt;
    logic              r_fault, w_fault_nxt;

    logic w_misal;     // current PC cannot be fetched
    logic w_expired;   // WAIT timed out
    logic w_resp_err;  // bus error as seen by the FSM

`ifdef YSYX_IFU_FAULT_EN
    assign w_misal    = (r_pc[1:0] != 2'b00);
    assign w_resp_err = i_resp_err;

    ysyx_24100005_ifu_wdog #(.LIMIT(TO_LIM)) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (r_state != WAIT),
        .i_en      (r_state == WAIT),
        .o_expired (w_expired)
    );
`else
    logic w_unused;
    assign w_unused   = ^{i_resp_err, TO_LIM};
    assign w_misal    = 1'b0;
    assign w_resp_err = 1'b0;
    assign w_expired  = 1'b0;
`endif

    assign o_req_addr   = r_pc;
    assign o_pc         = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_fault = r_fault;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= REQ;
        else        r_state <= w_state_nxt;
    end

    // PC / instruction / fault registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc    <= RESET_PC;
            r_inst  <= INST_ZERO;
            r_fault <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Next-state, next-data and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_inst_nxt   = r_inst;
        w_fault_nxt  = r_fault;
        o_req_valid  = 1'b0;
        o_resp_ready = 1'b0;
        o_inst_valid = 1'b0;
        unique case (r_state)
            REQ: begin
                if (w_misal) begin
                    // unfetchable PC: deliver a faulting zero instruction instead
                    w_state_nxt = HOLD;
                    w_inst_nxt  = INST_ZERO;
                    w_fault_nxt = 1'b1;
                end else begin
                    // gated by reset so the request drops the moment reset asserts
                    o_req_valid = i_rst;
                    if (i_req_ready) w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                o_resp_ready = 1'b1;
                if (i_resp_valid) begin
                    w_state_nxt = HOLD;
                    w_inst_nxt  = i_resp_data;
                    w_fault_nxt = w_resp_err;
                end else if (w_expired) begin
                    w_state_nxt = HOLD;
                    w_inst_nxt  = INST_ZERO;
                    w_fault_nxt = 1'b1;
                end
            end
            HOLD: begin
                o_inst_valid = 1'b1;
                if (i_inst_ready) begin
                    // single-cycle core may report its next PC in the same cycle
                    if (i_wb_valid) begin
                        w_pc_nxt    = i_wb_npc;
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (i_wb_valid) begin
                    w_pc_nxt    = i_wb_npc;
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed, table-driven bench for ysyx_24100005_ifu (also covers YSYX_IFU_FAULT_EN builds).
module tb_ysyx_24100005_ifu;

`ifdef YSYX_IFU_FAULT_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic        clk, rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic        inst_valid, inst_ready, wb_valid, inst_fault;
    logic [31:0] req_addr, resp_data, inst, pc, wb_npc;

    int n_chk = 0;
    int n_err = 0;

    ysyx_24100005_ifu dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_req_valid  (req_valid),
        .i_req_ready  (req_ready),
        .o_req_addr   (req_addr),
        .i_resp_valid (resp_valid),
        .o_resp_ready (resp_ready),
        .i_resp_data  (resp_data),
        .i_resp_err   (resp_err),
        .o_inst_valid (inst_valid),
        .i_inst_ready (inst_ready),
        .o_inst       (inst),
        .o_pc         (pc),
        .i_wb_valid   (wb_valid),
        .i_wb_npc     (wb_npc),
        .o_inst_fault (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one record = inputs for one cycle + expected state-driven outputs in that cycle
    typedef struct {
        logic        rr, rv, err, ir, wb;
        logic [31:0] d, npc;
        logic        e_rv, e_rr, e_iv, e_f;
        logic [31:0] e_inst, e_pc;
    } vec_t;

    function automatic vec_t mk(int rr, int rv, logic [31:0] d, int err, int ir, int wb,
                                logic [31:0] npc, int erv, int err_r, int eiv,
                                logic [31:0] einst, logic [31:0] epc, int ef);
        vec_t v;
        v.rr = (rr != 0); v.rv = (rv != 0); v.d = d; v.err = (err != 0);
        v.ir = (ir != 0); v.wb = (wb != 0); v.npc = npc;
        v.e_rv = (erv != 0); v.e_rr = (err_r != 0); v.e_iv = (eiv != 0);
        v.e_inst = einst; v.e_pc = epc; v.e_f = (ef != 0);
        return v;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_ready = 0; resp_valid = 0; resp_data = '0; resp_err = 0;
        inst_ready = 0; wb_valid = 0; wb_npc = '0;
    endtask

    task automatic chk_out(input string t, input logic erv, input logic err_r, input logic eiv,
                           input logic [31:0] einst, input logic [31:0] epc, input logic ef);
        chk1 ({t, ".req_valid"},  req_valid,  erv);
        chk1 ({t, ".resp_ready"}, resp_ready, err_r);
        chk1 ({t, ".inst_valid"}, inst_valid, eiv);
        chk32({t, ".inst"},       inst,       einst);
        chk32({t, ".pc"},         pc,         epc);
        chk32({t, ".req_addr"},   req_addr,   epc);
        chk1 ({t, ".inst_fault"}, inst_fault, ef);
    endtask

    localparam logic [31:0] P0  = 32'h8000_0000;
    localparam logic [31:0] P4  = 32'h8000_0004;
    localparam logic [31:0] P8  = 32'h8000_0008;
    localparam logic [31:0] P10 = 32'h8000_0010;
    localparam logic [31:0] J   = 32'h8000_0100;
    localparam logic [31:0] I1  = 32'h0010_0093;
    localparam logic [31:0] I2  = 32'h0020_0113;
    localparam logic [31:0] I3  = 32'h0030_0193;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    vec_t tv[26];

    initial begin
        // fetch, fetch with simultaneous wb, fetch+jump, req stall, err response, hold stall
        tv[0]  = mk(1,0,'0,0,0,0,'0,   1,0,0,'0,P0,0);
        tv[1]  = mk(0,1,I1,0,0,0,'0,   0,1,0,'0,P0,0);
        tv[2]  = mk(0,0,'0,0,1,0,'0,   0,0,1,I1,P0,0);
        tv[3]  = mk(0,0,'0,0,0,1,P4,   0,0,0,I1,P0,0);
        tv[4]  = mk(1,0,'0,0,0,0,'0,   1,0,0,I1,P4,0);
        tv[5]  = mk(0,1,I2,0,0,0,'0,   0,1,0,I1,P4,0);
        tv[6]  = mk(0,0,'0,0,1,1,P8,   0,0,1,I2,P4,0);
        tv[7]  = mk(1,0,'0,0,0,0,'0,   1,0,0,I2,P8,0);
        tv[8]  = mk(0,1,I3,0,0,0,'0,   0,1,0,I2,P8,0);
        tv[9]  = mk(0,0,'0,0,1,0,'0,   0,0,1,I3,P8,0);
        tv[10] = mk(0,0,'0,0,0,1,J,    0,0,0,I3,P8,0);
        tv[11] = mk(0,1,32'h1234_5678,0,0,0,'0, 1,0,0,I3,J,0);
        for (int k = 12; k < 16; k++)
            tv[k] = mk(0,0,'0,0,(k == 12) ? 1 : 0,0,'0, 1,0,0,I3,J,0);
        tv[16] = mk(1,0,'0,0,0,0,'0,   1,0,0,I3,J,0);
        tv[17] = mk(0,0,'0,0,0,0,'0,   0,1,0,I3,J,0);
        tv[18] = mk(0,1,DB,1,0,0,'0,   0,1,0,I3,J,0);
        tv[19] = mk(1,1,'0,0,0,0,'0,   0,0,1,DB,J,FE);
        for (int k = 20; k < 23; k++)
            tv[k] = mk(0,0,'0,0,0,0,'0, 0,0,1,DB,J,FE);
        tv[23] = mk(0,0,'0,0,1,1,P10,  0,0,1,DB,J,FE);
        tv[24] = mk(1,0,'0,0,0,0,'0,   1,0,0,DB,P10,FE);
        tv[25] = mk(0,0,'0,0,0,0,'0,   0,1,0,DB,P10,FE);

        // reset, with a stray req_ready that must not be taken
        idle_inputs();
        rst = 0;
        req_ready = 1;
        repeat (3) @(posedge clk);
        #1 chk_out("reset", 0, 0, 0, '0, P0, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1 chk1("post_reset.req_valid", req_valid, 1'b1);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            req_ready = tv[i].rr; resp_valid = tv[i].rv; resp_data = tv[i].d;
            resp_err = tv[i].err; inst_ready = tv[i].ir; wb_valid = tv[i].wb;
            wb_npc = tv[i].npc;
            #1 chk_out($sformatf("v%0d", i), tv[i].e_rv, tv[i].e_rr, tv[i].e_iv,
                       tv[i].e_inst, tv[i].e_pc, tv[i].e_f);
        end

        // reset in the middle of WAIT: outputs return to reset values at once
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #2 rst = 0;
        #1 chk_out("rst_wait", 0, 0, 0, '0, P0, 0);
        @(negedge clk);
        rst = 1;
        req_ready = 1;
        #1 chk_out("refetch.req", 1, 0, 0, '0, P0, 0);
        @(posedge clk);
        #1 req_ready = 0;
        resp_valid = 1; resp_data = 32'h0000_0013;
        chk1("refetch.resp_ready", resp_ready, 1'b1);
        @(posedge clk);
        #1 resp_valid = 0;
        chk_out("refetch.hold", 0, 0, 1, 32'h0000_0013, P0, 0);

`ifdef YSYX_IFU_FAULT_EN
        begin
            int n;
            // misaligned next PC: no request, faulting zero instruction
            inst_ready = 1; wb_valid = 1; wb_npc = 32'h8000_0002;
            @(posedge clk);
            #1 idle_inputs();
            chk1 ("misal.req_valid", req_valid, 1'b0);
            chk32("misal.req_addr",  req_addr,  32'h8000_0002);
            @(posedge clk);
            #1 chk_out("misal.hold", 0, 0, 1, '0, 32'h8000_0002, 1);
            // WAIT timeout: TIMEOUT_CYC+1 WAIT cycles (count 0..255) then fault
            inst_ready = 1; wb_valid = 1; wb_npc = 32'h8000_0020;
            @(posedge clk);
            #1 idle_inputs();
            req_ready = 1;
            chk1("to.req_valid", req_valid, 1'b1);
            @(posedge clk);
            #1 req_ready = 0;
            n = 0;
            while (!inst_valid && n < 400) begin
                @(posedge clk);
                #1 n++;
            end
            chk32("to.wait_cycles", n, 32'd256);
            chk_out("to.hold", 0, 0, 1, '0, 32'h8000_0020, 1);
            // late response for the timed-out request is not accepted
            resp_valid = 1; resp_data = 32'h0000_0055;
            #1 chk1("late.resp_ready", resp_ready, 1'b0);
            @(posedge clk);
            #1 resp_valid = 0;
            chk32("late.inst", inst, 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
